dht22_read_scheduler: RTL and testbench

Sequencing controller for the DHT22 reader (`top_dht22`). It issues `start_read` pulses periodically or on host request, and enforces the sensor's minimum inter-read interval. It supervises each transaction with a timeout and retry budget, and holds the last good reading stable for downstream logic. It sits between host/control logic and `top_dht22`, and owns that reader's `start_read` input exclusively.

---
 rtl/dht22_sched_pkg.sv | 16 +
 rtl/dht22_ms_tick.sv | 19 +
 rtl/dht22_read_scheduler.sv | 131 +++++++++++++
 tb/tb_dht22_read_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dht22_sched_pkg.sv
// dht22_sched_pkg: shared types, widths and helpers for the DHT22 read scheduler.
package dht22_sched_pkg;
  typedef enum logic [2:0] {IDLE, GUARD, START, WAIT, CAPTURE, COOLDOWN} sched_state_t;
  typedef logic [2:0][3:0] bcd3_t;
  localparam int INT_W = 16;
  localparam int PER_W = 18;
  function automatic int ms_to_cycles(input int clk_freq);
    return clk_freq / 1000;
  endfunction
  function automatic logic bcd3_ok(input bcd3_t v);
    return v[2] <= 4'd9 && v[1] <= 4'd9 && v[0] <= 4'd9;
  endfunction
  function automatic logic [10:0] bcd3_val(input bcd3_t v);
    return 11'(v[2]) * 11'd100 + 11'(v[1]) * 11'd10 + 11'(v[0]);
  endfunction
endpackage

// File: rtl/dht22_ms_tick.sv
// dht22_ms_tick: free-running divider emitting a one-cycle tick every DIV cycles.
module dht22_ms_tick #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic arstn,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= cnt == CW'(DIV - 1);
      cnt <= cnt == CW'(DIV - 1) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/dht22_read_scheduler.sv
// dht22_read_scheduler: paces, supervises and retries DHT22 reads, holding the last good sample.
// Define DHT22_SCHED_RANGE_CHECK_EN to reject captures with invalid BCD digits or humidity above 100.0.
module dht22_read_scheduler
  import dht22_sched_pkg::*;
#(
  parameter int CLK_FREQ        = 100000000,
  parameter int MIN_INTERVAL_MS = 2000,
  parameter int TIMEOUT_MS      = 10,
  parameter int MAX_RETRIES     = 3
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       enable,
  input  logic [7:0] period_s,
  input  logic       req,
  output logic       start_read,
  input  logic       sys_idle,
  input  logic       data_ready,
  input  bcd3_t      humidity_bcd_in,
  input  bcd3_t      temperature_bcd_in,
  input  logic       negativo_temp_in,
  output bcd3_t      humidity_bcd,
  output bcd3_t      temperature_bcd,
  output logic       negativo_temp,
  output logic       valid,
  output logic       busy,
  output logic       new_data,
  output logic       fail,
  output logic [7:0] err_cnt
);
  sched_state_t state;
  logic tick, pending, ret_idle, en_q, dr_q, si_q;
  logic dr_rise, si_rise, per_exp, trig, to_exp, bad, failed, guard_ok, retry_last;
  logic [INT_W-1:0] int_cnt, to_cnt;
  logic [PER_W-1:0] per_cnt, per_ms, per_load;
  logic [7:0] retry;

  dht22_ms_tick #(.DIV(ms_to_cycles(CLK_FREQ))) u_tick (.clk(clk), .arstn(arstn), .tick(tick));

  assign per_ms     = PER_W'(period_s) * PER_W'(1000);
  assign per_load   = per_ms < PER_W'(MIN_INTERVAL_MS) ? PER_W'(MIN_INTERVAL_MS) : per_ms;
  assign dr_rise    = data_ready && !dr_q;
  assign si_rise    = sys_idle && !si_q;
  // Expiry is the single tick that takes the counter to zero, so it triggers only once.
  assign per_exp    = enable && tick && per_cnt == PER_W'(1);
  assign trig       = req || per_exp;
  assign to_exp     = to_cnt >= INT_W'(TIMEOUT_MS);
  // Strictly greater: the free-running tick may land just after START, so this guarantees a full interval.
  assign guard_ok   = int_cnt > INT_W'(MIN_INTERVAL_MS) && sys_idle;
  assign retry_last = retry >= 8'(MAX_RETRIES);
`ifdef DHT22_SCHED_RANGE_CHECK_EN
  assign bad = !bcd3_ok(humidity_bcd_in) || !bcd3_ok(temperature_bcd_in) ||
               bcd3_val(humidity_bcd_in) > 11'd1000;
`else
  assign bad = 1'b0;
`endif
  assign failed = (state == WAIT && !dr_rise && (to_exp || si_rise)) || (state == CAPTURE && bad);

  always_ff @(posedge clk or negedge arstn)
    if (!arstn) begin
      state           <= IDLE;
      start_read      <= 1'b0;
      humidity_bcd    <= '0;
      temperature_bcd <= '0;
      negativo_temp   <= 1'b0;
      valid           <= 1'b0;
      busy            <= 1'b0;
      new_data        <= 1'b0;
      fail            <= 1'b0;
      err_cnt         <= '0;
      pending         <= 1'b0;
      ret_idle        <= 1'b0;
      en_q            <= 1'b0;
      dr_q            <= 1'b0;
      si_q            <= 1'b0;
      int_cnt         <= '1;
      to_cnt          <= '0;
      per_cnt         <= '0;
      retry           <= '0;
    end else begin
      en_q       <= enable;
      dr_q       <= data_ready;
      si_q       <= sys_idle;
      start_read <= 1'b0;
      new_data   <= 1'b0;
      fail       <= 1'b0;
      int_cnt    <= state == START ? '0 : tick && int_cnt != '1 ? int_cnt + 1'b1 : int_cnt;
      to_cnt     <= state == START ? '0 : tick && to_cnt != '1 ? to_cnt + 1'b1 : to_cnt;
      if ((enable && !en_q) || (state == START && enable && per_cnt == '0))
        per_cnt <= per_load;
      else if (enable && tick && per_cnt != '0)
        per_cnt <= per_cnt - 1'b1;
      if (trig && state != IDLE)
        pending <= 1'b1;
      if (failed) begin
        err_cnt  <= err_cnt == 8'hFF ? err_cnt : err_cnt + 1'b1;
        retry    <= retry_last ? '0 : retry + 1'b1;
        fail     <= retry_last;
        ret_idle <= retry_last;
        state    <= COOLDOWN;
      end else
        case (state)
          IDLE: if (trig || pending) begin
            state   <= GUARD;
            busy    <= 1'b1;
            pending <= 1'b0;
          end
          GUARD: if (guard_ok) begin
            state      <= START;
            start_read <= 1'b1;
          end
          START: state <= WAIT;
          WAIT: if (dr_rise) state <= CAPTURE;
          CAPTURE: begin
            humidity_bcd    <= humidity_bcd_in;
            temperature_bcd <= temperature_bcd_in;
            negativo_temp   <= negativo_temp_in;
            new_data        <= 1'b1;
            valid           <= 1'b1;
            retry           <= '0;
            ret_idle        <= 1'b1;
            state           <= COOLDOWN;
          end
          COOLDOWN: begin
            state <= ret_idle ? IDLE : GUARD;
            busy  <= !ret_idle;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_dht22_read_scheduler.sv
// tb_dht22_read_scheduler: directed table plus multi-cycle sequences against a simple reader agent.
module tb_dht22_read_scheduler;
  logic clk = 1'b0, arstn = 1'b0, enable = 1'b0, req = 1'b0;
  logic sys_idle = 1'b1, data_ready = 1'b0, negativo_temp_in = 1'b0;
  logic [7:0] period_s = 8'd0;
  logic [11:0] hum_in = '0, tmp_in = '0;
  logic start_read, negativo_temp, valid, busy, new_data, fail;
  logic [11:0] humidity_bcd, temperature_bcd;
  logic [7:0] err_cnt;

  dht22_read_scheduler #(.CLK_FREQ(100000), .MIN_INTERVAL_MS(20), .TIMEOUT_MS(5), .MAX_RETRIES(2)) dut (
    .clk(clk), .arstn(arstn), .enable(enable), .period_s(period_s), .req(req),
    .start_read(start_read), .sys_idle(sys_idle), .data_ready(data_ready),
    .humidity_bcd_in(hum_in), .temperature_bcd_in(tmp_in), .negativo_temp_in(negativo_temp_in),
    .humidity_bcd(humidity_bcd), .temperature_bcd(temperature_bcd), .negativo_temp(negativo_temp),
    .valid(valid), .busy(busy), .new_data(new_data), .fail(fail), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int sr_cnt = 0, sr_last = 0, sr_gap = 0, nd_cnt = 0, nd_cyc = 0, fail_cnt = 0;
  int dr_cyc = 0, req_cyc = 0, drop_left = 0;
  logic silent = 1'b0;

  typedef struct {
    logic [11:0] hum, tmp;
    logic        neg;
    logic [11:0] e_hum, e_tmp;
    logic        e_neg;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int cnt_of(input int which);
    return which == 0 ? sr_cnt : which == 1 ? nd_cnt : which == 2 ? fail_cnt : int'(!busy);
  endfunction

  task automatic wait_ev(input string name, input int which, input int target, input int limit);
    int n = 0;
    while (cnt_of(which) < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, cnt_of(which) >= target, 1);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    req = 1'b1;
    req_cyc = cyc;
    @(negedge clk);
    req = 1'b0;
  endtask

  // Pulse monitor, sampled between edges.
  initial forever begin
    @(posedge clk);
    #2;
    if (start_read) begin
      sr_cnt++;
      sr_gap = cyc - sr_last;
      sr_last = cyc;
    end
    if (new_data) begin
      nd_cnt++;
      nd_cyc = cyc;
    end
    if (fail) fail_cnt++;
  end

  // Reader agent: answer after 3 ms, drop (idle rises with no data) after 2 ms, or stay silent.
  initial forever begin
    @(negedge clk);
    if (start_read && !silent) begin
      sys_idle = 1'b0;
      if (drop_left > 0) begin
        drop_left--;
        repeat (200) @(negedge clk);
        sys_idle = 1'b1;
      end else begin
        repeat (300) @(negedge clk);
        data_ready = 1'b1;
        sys_idle = 1'b1;
        dr_cyc = cyc;
        @(negedge clk);
        data_ready = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s0, n0, f0;
    vecs[0] = '{12'h601, 12'h250, 1'b0, 12'h601, 12'h250, 1'b0};
    vecs[1] = '{12'h999, 12'h999, 1'b1, 12'h999, 12'h999, 1'b1};
    vecs[2] = '{12'h000, 12'h001, 1'b1, 12'h000, 12'h001, 1'b1};
    vecs[3] = '{12'h455, 12'h123, 1'b0, 12'h455, 12'h123, 1'b0};
    vecs[4] = '{12'hA12, 12'h0F0, 1'b0, 12'hA12, 12'h0F0, 1'b0};

    repeat (5) @(negedge clk);
    chk("rst_start_read", start_read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_new_data", new_data, 0);
    chk("rst_fail", fail, 0);
    chk("rst_hum", humidity_bcd, 0);
    arstn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      hum_in = vecs[i].hum;
      tmp_in = vecs[i].tmp;
      negativo_temp_in = vecs[i].neg;
      s0 = sr_cnt;
      n0 = nd_cnt;
      pulse_req();
      if (i == 0) begin
        wait_ev("first_start", 0, s0 + 1, 50);
        chk("req_to_start", sr_last - req_cyc, 2);
      end
      wait_ev("vec_new_data", 1, n0 + 1, 4000);
      if (i == 0) chk("dr_to_new_data", nd_cyc - dr_cyc, 2);
      chk("vec_hum", humidity_bcd, vecs[i].e_hum);
      chk("vec_tmp", temperature_bcd, vecs[i].e_tmp);
      chk("vec_neg", negativo_temp, vecs[i].e_neg);
      chk("vec_valid", valid, 1);
      chk("vec_starts", sr_cnt - s0, 1);
      wait_ev("vec_idle", 3, 1, 20);
    end

    // Retries exhausted: silent reader.
    silent = 1'b1;
    s0 = sr_cnt; n0 = nd_cnt; f0 = fail_cnt;
    pulse_req();
    wait_ev("exhaust_fail", 2, f0 + 1, 10000);
    wait_ev("exhaust_idle", 3, 1, 20);
    chk("exhaust_starts", sr_cnt - s0, 3);
    chk("exhaust_fail_pulses", fail_cnt - f0, 1);
    chk("exhaust_err_cnt", err_cnt, 3);
    chk("exhaust_retry_gap", sr_gap >= 2000, 1);
    chk("exhaust_valid", valid, 1);
    chk("exhaust_hum_hold", humidity_bcd, 12'hA12);
    chk("exhaust_tmp_hold", temperature_bcd, 12'h0F0);
    chk("exhaust_no_new_data", nd_cnt - n0, 0);
    silent = 1'b0;

    // One dropped transaction, then recovery on the retry.
    @(negedge clk);
    hum_in = 12'h372; tmp_in = 12'h085; negativo_temp_in = 1'b1;
    drop_left = 1;
    s0 = sr_cnt; n0 = nd_cnt; f0 = fail_cnt;
    pulse_req();
    wait_ev("recover_new_data", 1, n0 + 1, 8000);
    chk("recover_err_cnt", err_cnt, 4);
    chk("recover_no_fail", fail_cnt - f0, 0);
    chk("recover_starts", sr_cnt - s0, 2);
    chk("recover_gap", sr_gap >= 2000, 1);
    chk("recover_hum", humidity_bcd, 12'h372);
    chk("recover_neg", negativo_temp, 1);
    wait_ev("recover_idle", 3, 1, 20);

    // Back-to-back requests during WAIT collapse into one extra transaction.
    s0 = sr_cnt; n0 = nd_cnt;
    pulse_req();
    wait_ev("b2b_first_start", 0, s0 + 1, 4000);
    repeat (10) @(negedge clk);
    pulse_req();
    repeat (10) @(negedge clk);
    pulse_req();
    wait_ev("b2b_new_data", 1, n0 + 2, 6000);
    wait_ev("b2b_idle", 3, 1, 20);
    chk("b2b_gap", sr_gap >= 2000, 1);
    repeat (3000) @(negedge clk);
    chk("b2b_starts", sr_cnt - s0, 2);

    // Periodic mode with a clamped period.
    @(negedge clk);
    enable = 1'b1;
    period_s = 8'd0;
    s0 = sr_cnt; n0 = nd_cnt;
    for (int i = 0; i < 5; i++) begin
      wait_ev("periodic_start", 0, s0 + i + 1, 2600);
      if (i > 0) chk("periodic_gap", sr_gap >= 1900 && sr_gap <= 2105, 1);
    end
    enable = 1'b0;
    wait_ev("periodic_new_data", 1, n0 + 5, 1000);
    wait_ev("periodic_idle", 3, 1, 20);

    // Reset in WAIT, then an unguarded request.
    s0 = sr_cnt;
    pulse_req();
    wait_ev("rw_start", 0, s0 + 1, 4000);
    repeat (200) @(negedge clk);
    arstn = 1'b0;
    #1;
    chk("rw_valid", valid, 0);
    chk("rw_busy", busy, 0);
    chk("rw_err_cnt", err_cnt, 0);
    chk("rw_hum", humidity_bcd, 0);
    chk("rw_tmp", temperature_bcd, 0);
    chk("rw_start_read", start_read, 0);
    repeat (150) @(negedge clk);
    arstn = 1'b1;
    hum_in = 12'h588; tmp_in = 12'h211; negativo_temp_in = 1'b0;
    s0 = sr_cnt; n0 = nd_cnt;
    pulse_req();
    wait_ev("rw_restart", 0, s0 + 1, 50);
    chk("rw_req_to_start", sr_last - req_cyc, 2);
    wait_ev("rw_new_data", 1, n0 + 1, 1000);
    chk("rw_hum_new", humidity_bcd, 12'h588);
    chk("rw_valid_new", valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
